// File: rtl/subbytes_engine.sv
// Time-multiplexed AES SubBytes/InvSubBytes over LANES algebraic S-boxes; result valid BEATS=16/LANES cycles after accept.
// Finished block holds in DONE until out_ready; in_ready is IDLE or (DONE and out_ready), never dependent on in_valid.
module subbytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
            $error("subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          fsm_q, fsm_d;
    logic [127:0]    st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            inv_q, inv_d;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
        logic [7:0] t;
        logic [7:0] g;
        t = inv ? ({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05) : b;
        g = gf_inv(t);
        return inv ? g : (g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]}
                          ^ {g[3:0], g[7:4]} ^ 8'h63);
    endfunction

    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = st_q[8*(15 - (int'(cnt_q) * LANES + l)) +: 8];
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign lane_out[g] = sbox(lane_in[g], inv_q);
        end
    endgenerate

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        cnt_d = cnt_q;
        inv_d = inv_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d  = in_state;
                    inv_d = in_inv;
                    cnt_d = '0;
                    fsm_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    st_d[8*(15 - (int'(cnt_q) * LANES + l)) +: 8] = lane_out[l];
                end
                if (cnt_q == CW'(BEATS - 1)) begin
                    cnt_d = '0;
                    fsm_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        st_d  = in_state;
                        inv_d = in_inv;
                        cnt_d = '0;
                        fsm_d = S_RUN;
                    end else begin
                        fsm_d = S_IDLE;
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= S_IDLE;
            st_q  <= '0;
            cnt_q <= '0;
            inv_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            cnt_q <= cnt_d;
            inv_q <= inv_d;
        end
    end

    assign in_ready  = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && out_ready);
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q != S_IDLE);
    assign out_state = st_q;

endmodule

// File: tb/tb_subbytes_engine.sv
// Directed bench for subbytes_engine: vector table at LANES=4, lane sweep, backpressure, back-to-back and mid-run reset.
module tb_subbytes_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;

    logic         sw_valid, sw_inv, sw_ready;
    logic [3:0]   sw_iready, sw_ovalid, sw_busy;
    logic [127:0] sw_state;
    logic [127:0] sw_ostate [4];

    subbytes_engine #(.LANES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy));
    subbytes_engine #(.LANES(1)) u_sw0 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_iready[0]), .in_state(sw_state),
        .in_inv(sw_inv), .out_valid(sw_ovalid[0]), .out_ready(sw_ready), .out_state(sw_ostate[0]), .busy(sw_busy[0]));
    subbytes_engine #(.LANES(2)) u_sw1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_iready[1]), .in_state(sw_state),
        .in_inv(sw_inv), .out_valid(sw_ovalid[1]), .out_ready(sw_ready), .out_state(sw_ostate[1]), .busy(sw_busy[1]));
    subbytes_engine #(.LANES(8)) u_sw2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_iready[2]), .in_state(sw_state),
        .in_inv(sw_inv), .out_valid(sw_ovalid[2]), .out_ready(sw_ready), .out_state(sw_ostate[2]), .busy(sw_busy[2]));
    subbytes_engine #(.LANES(16)) u_sw3 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_iready[3]), .in_state(sw_state),
        .in_inv(sw_inv), .out_valid(sw_ovalid[3]), .out_ready(sw_ready), .out_state(sw_ostate[3]), .busy(sw_busy[3]));

    typedef struct {
        logic [127:0] st;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT_S = 128'h638293c31bfc33f5c4eeacea4bc12816;

    vec_t         vecs [8];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           sw_lat [4];
    int           sw_exp_lat [4] = '{16, 8, 2, 1};
    logic [127:0] res, ra, rb;
    int           lat, t1, t2, spurious;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one block at the current negedge and wait (bounded) for out_valid.
    task automatic run_main(input logic [127:0] st, input logic inv,
                            output logic [127:0] r, output int l);
        in_state = st;
        in_inv   = inv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("run_busy", 128'(busy), 128'd1);
        check("run_in_ready_low", 128'(in_ready), 128'd0);
        l = 0;
        r = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                l = k;
                r = out_state;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{st: PT, inv: 1'b0, exp: PT_S};
        vecs[1] = '{st: PT_S, inv: 1'b1, exp: PT};
        vecs[2] = '{st: 128'h193de3bea0f4e22b9ac68d2ae9f84808, inv: 1'b0,
                    exp: 128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[3] = '{st: 128'hd42711aee0bf98f1b8b45de51e415230, inv: 1'b1,
                    exp: 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[4] = '{st: 128'h0, inv: 1'b0, exp: {16{8'h63}}};
        vecs[5] = '{st: {16{8'h63}}, inv: 1'b1, exp: 128'h0};
        vecs[6] = '{st: 128'h0, inv: 1'b1, exp: {16{8'h52}}};
        vecs[7] = '{st: {16{8'hff}}, inv: 1'b0, exp: {16{8'h16}}};

        rst = 1'b1;
        in_valid = 1'b0; in_state = '0; in_inv = 1'b0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_state = '0; sw_inv = 1'b0; sw_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        check("reset_out_state", out_state, 128'd0);
        check("reset_sweep_in_ready", 128'(sw_iready), 128'hf);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            check($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'd1);
            run_main(vecs[i].st, vecs[i].inv, res, lat);
            check($sformatf("vec%0d_state", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
            @(negedge clk);
        end

        sw_state = PT; sw_inv = 1'b0; sw_ready = 1'b0; sw_valid = 1'b1;
        for (int i = 0; i < 4; i++) sw_lat[i] = 0;
        @(negedge clk);
        sw_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (sw_ovalid[i] && sw_lat[i] == 0) sw_lat[i] = k;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sweep%0d_state", i), sw_ostate[i], PT_S);
            check($sformatf("sweep%0d_latency", i), 128'(sw_lat[i]), 128'(sw_exp_lat[i]));
        end
        sw_ready = 1'b1;
        @(negedge clk);
        check("sweep_drained", 128'(sw_ovalid), 128'd0);

        out_ready = 1'b0;
        run_main(PT, 1'b0, res, lat);
        check("bp_first_state", res, PT_S);
        check("bp_first_latency", 128'(lat), 128'd4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 128'(out_valid), 128'd1);
            check("bp_hold_state", out_state, PT_S);
            check("bp_hold_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        in_state = PT_S; in_inv = 1'b1; in_valid = 1'b1;
        #1;
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_handshake_run", 128'(busy && !out_valid), 128'd1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                res = out_state;
                break;
            end
        end
        check("bp_second_state", res, PT);
        check("bp_second_latency", 128'(lat), 128'd4);

        @(negedge clk);
        in_state = PT; in_inv = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_state = PT_S; in_inv = 1'b1;
        t1 = 0; t2 = 0; ra = '0; rb = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (t1 != 0 && k == t1 + 1) in_valid = 1'b0;
            if (out_valid && t1 == 0) begin
                t1 = k;
                ra = out_state;
                check("b2b_in_ready_done", 128'(in_ready), 128'd1);
            end else if (out_valid && t1 != 0 && k > t1 + 1) begin
                t2 = k;
                rb = out_state;
                break;
            end
        end
        in_valid = 1'b0;
        check("b2b_a_state", ra, PT_S);
        check("b2b_b_state", rb, PT);
        check("b2b_a_latency", 128'(t1), 128'd4);
        check("b2b_period", 128'(t2 - t1), 128'd5);

        @(negedge clk);
        in_state = vecs[2].st; in_inv = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(out_valid), 128'd0);
        check("rst_mid_busy", 128'(busy), 128'd0);
        check("rst_mid_in_ready", 128'(in_ready), 128'd1);
        check("rst_mid_out_state", out_state, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid || busy) spurious++;
        end
        check("rst_no_spurious_valid", 128'(spurious), 128'd0);
        run_main(vecs[2].st, 1'b0, res, lat);
        check("rst_after_state", res, vecs[2].exp);
        check("rst_after_latency", 128'(lat), 128'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
